// File: rtl/tlb_assoc.sv
// tlb_assoc: set-associative TLB, two lookup ports, round-robin refill, flush engine.
// Define TLB_ASID_EN to store/compare ASID and global bits and walk sets on ASID flush.
module tlb_assoc #(
  parameter int VPN_W  = 27,
  parameter int DATA_W = 44,
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int ASID_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ASID_W-1:0] cur_asid,
  input  logic [VPN_W-1:0]  if_vpn,
  output logic              if_hit,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              if_update,
  input  logic [DATA_W-1:0] if_wdata,
  input  logic              if_wglobal,
  input  logic [VPN_W-1:0]  ma_vpn,
  output logic              ma_hit,
  output logic [DATA_W-1:0] ma_rdata,
  input  logic              ma_update,
  input  logic [DATA_W-1:0] ma_wdata,
  input  logic              ma_wglobal,
  input  logic              flush_req,
  input  logic [1:0]        flush_mode,
  input  logic [VPN_W-1:0]  flush_vpn,
  input  logic [ASID_W-1:0] flush_asid,
  output logic              flush_busy,
  output logic              flush_done
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = VPN_W - IDX_W;
  localparam int WP_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] widx;

  logic [WAYS-1:0]   vld   [SETS];
  logic [TAG_W-1:0]  tag_q [SETS][WAYS];
  logic [DATA_W-1:0] dat_q [SETS][WAYS];
  logic [WP_W-1:0]   rr    [SETS];
`ifdef TLB_ASID_EN
  logic [WAYS-1:0]   glb    [SETS];
  logic [ASID_W-1:0] asid_q [SETS][WAYS];
  logic [ASID_W-1:0] fasid;
  logic [WAYS-1:0]   wk_m;
  logic              wr_glob;
`else
  logic unused_ok;
  assign unused_ok = ^{cur_asid, flush_asid, if_wglobal, ma_wglobal};
`endif

  logic [IDX_W-1:0]  if_idx, ma_idx, fl_idx, wr_idx;
  logic [TAG_W-1:0]  if_tag, ma_tag, fl_tag, wr_tag;
  logic [WAYS-1:0]   if_m, ma_m, fl_m, wr_m;
  logic [DATA_W-1:0] wr_data;
  logic [WP_W-1:0]   wr_way;
  logic              wr_adv, wr_en;
  logic              busy, accept;
  logic              f_all, f_vpn, f_asid;

  assign if_idx = if_vpn[IDX_W-1:0];
  assign if_tag = if_vpn[VPN_W-1:IDX_W];
  assign ma_idx = ma_vpn[IDX_W-1:0];
  assign ma_tag = ma_vpn[VPN_W-1:IDX_W];
  assign fl_idx = flush_vpn[IDX_W-1:0];
  assign fl_tag = flush_vpn[VPN_W-1:IDX_W];

  assign busy       = (state != IDLE);
  assign accept     = (state == IDLE) && flush_req;
  assign flush_busy = busy;
  assign flush_done = (state == DONE);

  always_comb begin
    if_m = '0;
    ma_m = '0;
    fl_m = '0;
`ifdef TLB_ASID_EN
    wk_m = '0;
`endif
    for (int w = 0; w < WAYS; w++) begin
      if_m[w] = vld[if_idx][w] && (tag_q[if_idx][w] == if_tag);
      ma_m[w] = vld[ma_idx][w] && (tag_q[ma_idx][w] == ma_tag);
      fl_m[w] = vld[fl_idx][w] && (tag_q[fl_idx][w] == fl_tag);
`ifdef TLB_ASID_EN
      if_m[w] = if_m[w] &&
                (glb[if_idx][w] || asid_q[if_idx][w] == cur_asid);
      ma_m[w] = ma_m[w] &&
                (glb[ma_idx][w] || asid_q[ma_idx][w] == cur_asid);
      wk_m[w] = vld[widx][w] && !glb[widx][w] &&
                (asid_q[widx][w] == fasid);
`endif
    end
  end

  // descending scan so the lowest matching way wins
  always_comb begin
    if_hit   = 1'b0;
    if_rdata = '0;
    ma_hit   = 1'b0;
    ma_rdata = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (if_m[w] && !busy) begin
        if_hit   = 1'b1;
        if_rdata = dat_q[if_idx][w];
      end
      if (ma_m[w] && !busy) begin
        ma_hit   = 1'b1;
        ma_rdata = dat_q[ma_idx][w];
      end
    end
  end

  // MA refill takes the single write port; a concurrent IF refill is dropped
  assign wr_en   = (if_update || ma_update) && !busy && !accept;
  assign wr_idx  = ma_update ? ma_idx : if_idx;
  assign wr_tag  = ma_update ? ma_tag : if_tag;
  assign wr_data = ma_update ? ma_wdata : if_wdata;
  assign wr_m    = ma_update ? ma_m : if_m;
`ifdef TLB_ASID_EN
  assign wr_glob = ma_update ? ma_wglobal : if_wglobal;
`endif

  always_comb begin
    wr_way = rr[wr_idx];
    wr_adv = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!vld[wr_idx][w]) begin
        wr_way = WP_W'(w);
        wr_adv = 1'b0;
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (wr_m[w]) begin
        wr_way = WP_W'(w);
        wr_adv = 1'b0;
      end
    end
  end

  always_comb begin
    f_all  = 1'b0;
    f_vpn  = 1'b0;
    f_asid = 1'b0;
    if (accept) begin
      unique case (flush_mode)
        2'd1: f_vpn = 1'b1;
`ifdef TLB_ASID_EN
        2'd2: f_asid = 1'b1;
`endif
        default: f_all = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (f_asid)      state_n = WALK;
        else if (accept) state_n = DONE;
      end
      WALK:    if (&widx) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      widx  <= '0;
      for (int s = 0; s < SETS; s++) begin
        vld[s] <= '0;
        rr[s]  <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w] <= '0;
          dat_q[s][w] <= '0;
`ifdef TLB_ASID_EN
          asid_q[s][w] <= '0;
`endif
        end
`ifdef TLB_ASID_EN
        glb[s] <= '0;
`endif
      end
`ifdef TLB_ASID_EN
      fasid <= '0;
`endif
    end else begin
      state <= state_n;
      widx  <= (state == WALK) ? widx + 1'b1 : '0;
      if (f_all) begin
        for (int s = 0; s < SETS; s++) vld[s] <= '0;
      end
      if (f_vpn) vld[fl_idx] <= vld[fl_idx] & ~fl_m;
`ifdef TLB_ASID_EN
      if (f_asid) fasid <= flush_asid;
      if (state == WALK) vld[widx] <= vld[widx] & ~wk_m;
`endif
      if (wr_en) begin
        vld[wr_idx][wr_way]   <= 1'b1;
        tag_q[wr_idx][wr_way] <= wr_tag;
        dat_q[wr_idx][wr_way] <= wr_data;
`ifdef TLB_ASID_EN
        glb[wr_idx][wr_way]    <= wr_glob;
        asid_q[wr_idx][wr_way] <= cur_asid;
`endif
        if (wr_adv) begin
          rr[wr_idx] <= (rr[wr_idx] == WP_W'(WAYS - 1)) ?
                        '0 : rr[wr_idx] + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tlb_assoc.sv
// tb_tlb_assoc: directed + random stimulus against an entry-level model,
// with a queue-based scoreboard and an independent monitor.
module tb_tlb_assoc;
  localparam int VPN_W  = 27;
  localparam int DATA_W = 44;
  localparam int SETS   = 16;
  localparam int WAYS   = 2;
  localparam int ASID_W = 16;
`ifdef TLB_ASID_EN
  localparam bit ASID_EN = 1'b1;
`else
  localparam bit ASID_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ASID_W-1:0] cur_asid;
  logic [VPN_W-1:0]  if_vpn, ma_vpn, flush_vpn;
  logic              if_hit, ma_hit;
  logic [DATA_W-1:0] if_rdata, ma_rdata, if_wdata, ma_wdata;
  logic              if_update, ma_update, if_wglobal, ma_wglobal;
  logic              flush_req, flush_busy, flush_done;
  logic [1:0]        flush_mode;
  logic [ASID_W-1:0] flush_asid;

  tlb_assoc #(
    .VPN_W(VPN_W), .DATA_W(DATA_W), .SETS(SETS),
    .WAYS(WAYS), .ASID_W(ASID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cur_asid(cur_asid),
    .if_vpn(if_vpn), .if_hit(if_hit), .if_rdata(if_rdata),
    .if_update(if_update), .if_wdata(if_wdata), .if_wglobal(if_wglobal),
    .ma_vpn(ma_vpn), .ma_hit(ma_hit), .ma_rdata(ma_rdata),
    .ma_update(ma_update), .ma_wdata(ma_wdata), .ma_wglobal(ma_wglobal),
    .flush_req(flush_req), .flush_mode(flush_mode),
    .flush_vpn(flush_vpn), .flush_asid(flush_asid),
    .flush_busy(flush_busy), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic ih; logic [DATA_W-1:0] ir;
    logic mh; logic [DATA_W-1:0] mr;
    logic busy; logic done;
  } exp_t;
  exp_t q[$];

  typedef struct {
    bit v; bit g; bit [ASID_W-1:0] asid;
    bit [VPN_W-1:0] vpn; bit [DATA_W-1:0] data;
  } ent_t;
  ent_t m[SETS][WAYS];
  int   ptr[SETS];
  int   walk_left;
  bit   done_pend;
  bit [ASID_W-1:0] m_fasid;

  bit              st_rst = 1'b0;
  bit [ASID_W-1:0] st_asid = '0, st_fasid = '0;
  bit [VPN_W-1:0]  st_if_vpn = '0, st_ma_vpn = '0, st_fvpn = '0;
  bit [DATA_W-1:0] st_if_wd = '0, st_ma_wd = '0;
  bit              st_if_upd = 0, st_ma_upd = 0, st_if_g = 0, st_ma_g = 0;
  bit              st_freq = 0;
  bit [1:0]        st_mode = '0;

  int tests = 0;
  int fails = 0;

  task automatic chk(string n, logic [63:0] a, logic [63:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
    end
  endtask

  function automatic int set_of(bit [VPN_W-1:0] vpn);
    return int'(vpn % SETS);
  endfunction

  function automatic int m_find(bit [VPN_W-1:0] vpn, bit [ASID_W-1:0] a);
    int s = set_of(vpn);
    for (int w = 0; w < WAYS; w++)
      if (m[s][w].v && m[s][w].vpn == vpn &&
          (!ASID_EN || m[s][w].g || m[s][w].asid == a))
        return w;
    return -1;
  endfunction

  function automatic bit m_busy();
    return (walk_left > 0) || done_pend;
  endfunction

  task automatic m_reset();
    for (int s = 0; s < SETS; s++) begin
      ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) m[s][w].v = 1'b0;
    end
    walk_left = 0;
    done_pend = 1'b0;
  endtask

  task automatic m_refill(bit [VPN_W-1:0] vpn, bit [DATA_W-1:0] d, bit g);
    int s = set_of(vpn);
    int w = m_find(vpn, st_asid);
    for (int i = WAYS - 1; i >= 0; i--)
      if (w < 0 || (m_find(vpn, st_asid) < 0 && !m[s][i].v))
        if (!m[s][i].v) w = i;
    if (w < 0) begin
      w = ptr[s];
      ptr[s] = (ptr[s] + 1) % WAYS;
    end
    m[s][w].v    = 1'b1;
    m[s][w].g    = ASID_EN ? g : 1'b0;
    m[s][w].asid = st_asid;
    m[s][w].vpn  = vpn;
    m[s][w].data = d;
  endtask

  task automatic m_edge();
    bit busy = m_busy();
    bit acc  = !busy && st_freq;
    int s;
    if (done_pend) done_pend = 1'b0;
    if (walk_left > 0) begin
      s = SETS - walk_left;
      for (int w = 0; w < WAYS; w++)
        if (m[s][w].v && !m[s][w].g && m[s][w].asid == m_fasid)
          m[s][w].v = 1'b0;
      walk_left--;
      if (walk_left == 0) done_pend = 1'b1;
    end
    if (acc) begin
      if (st_mode == 2'd1) begin
        s = set_of(st_fvpn);
        for (int w = 0; w < WAYS; w++)
          if (m[s][w].vpn == st_fvpn) m[s][w].v = 1'b0;
        done_pend = 1'b1;
      end else if (st_mode == 2'd2 && ASID_EN) begin
        walk_left = SETS;
        m_fasid   = st_fasid;
      end else begin
        for (int i = 0; i < SETS; i++)
          for (int w = 0; w < WAYS; w++) m[i][w].v = 1'b0;
        done_pend = 1'b1;
      end
    end else if (!busy) begin
      if (st_ma_upd)      m_refill(st_ma_vpn, st_ma_wd, st_ma_g);
      else if (st_if_upd) m_refill(st_if_vpn, st_if_wd, st_if_g);
    end
  endtask

  task automatic step();
    exp_t e;
    int wi, wm;
    @(negedge clk);
    rst_n      = st_rst;
    cur_asid   = st_asid;
    if_vpn     = st_if_vpn;
    ma_vpn     = st_ma_vpn;
    if_update  = st_if_upd;
    ma_update  = st_ma_upd;
    if_wdata   = st_if_wd;
    ma_wdata   = st_ma_wd;
    if_wglobal = st_if_g;
    ma_wglobal = st_ma_g;
    flush_req  = st_freq;
    flush_mode = st_mode;
    flush_vpn  = st_fvpn;
    flush_asid = st_fasid;
    if (!st_rst) m_reset();
    e = '0;
    e.busy = m_busy();
    e.done = done_pend;
    wi = m_find(st_if_vpn, st_asid);
    wm = m_find(st_ma_vpn, st_asid);
    if (!e.busy && wi >= 0) begin
      e.ih = 1'b1;
      e.ir = m[set_of(st_if_vpn)][wi].data;
    end
    if (!e.busy && wm >= 0) begin
      e.mh = 1'b1;
      e.mr = m[set_of(st_ma_vpn)][wm].data;
    end
    q.push_back(e);
    @(posedge clk);
    if (st_rst) m_edge();
    st_if_upd = 1'b0;
    st_ma_upd = 1'b0;
    st_freq   = 1'b0;
  endtask

  task automatic refill_if(bit [VPN_W-1:0] v, bit [DATA_W-1:0] d, bit g);
    st_if_vpn = v; st_if_wd = d; st_if_g = g; st_if_upd = 1'b1;
    step();
  endtask

  task automatic look(bit [VPN_W-1:0] a, bit [VPN_W-1:0] b);
    st_if_vpn = a; st_ma_vpn = b;
    step();
  endtask

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("if_hit", 64'(if_hit), 64'(e.ih));
      chk("if_rdata", 64'(if_rdata), 64'(e.ir));
      chk("ma_hit", 64'(ma_hit), 64'(e.mh));
      chk("ma_rdata", 64'(ma_rdata), 64'(e.mr));
      chk("flush_busy", 64'(flush_busy), 64'(e.busy));
      chk("flush_done", 64'(flush_done), 64'(e.done));
    end
  end

  initial begin
    rst_n = 1'b0; cur_asid = '0; if_vpn = '0; ma_vpn = '0;
    if_update = 1'b0; ma_update = 1'b0; if_wdata = '0; ma_wdata = '0;
    if_wglobal = 1'b0; ma_wglobal = 1'b0; flush_req = 1'b0;
    flush_mode = '0; flush_vpn = '0; flush_asid = '0;
    m_reset();
    step();
    step();
    st_rst = 1'b1;
    step();
    refill_if(27'h123, 44'hABC, 1'b0);
    look(27'h123, 27'h133);
    refill_if(27'h10, 44'h1010, 1'b0);
    refill_if(27'h20, 44'h2020, 1'b0);
    refill_if(27'h30, 44'h3030, 1'b0);
    look(27'h10, 27'h20);
    look(27'h30, 27'h10);
    refill_if(27'h40, 44'h4040, 1'b0);
    look(27'h20, 27'h40);
    look(27'h30, 27'h10);
    st_if_vpn = 27'h05; st_if_wd = 44'h555; st_if_upd = 1'b1;
    st_ma_vpn = 27'h06; st_ma_wd = 44'h666; st_ma_upd = 1'b1;
    step();
    look(27'h05, 27'h06);
    st_ma_vpn = 27'h06; st_ma_wd = 44'h777; st_ma_upd = 1'b1;
    step();
    refill_if(27'h26, 44'h2626, 1'b0);
    look(27'h06, 27'h26);
    st_asid = 16'd3;
    refill_if(27'h11, 44'h1111, 1'b0);
    st_asid = 16'd4;
    refill_if(27'h12, 44'h1212, 1'b0);
    refill_if(27'h13, 44'h1313, 1'b1);
    st_freq = 1'b1; st_mode = 2'd2; st_fasid = 16'd3;
    step();
    for (int i = 0; i < 20; i++) begin
      st_asid = (i % 2 == 0) ? 16'd3 : 16'd4;
      if (i == 5) begin st_freq = 1'b1; st_mode = 2'd0; end
      look(27'h11, 27'h12);
    end
    st_asid = 16'd3;
    look(27'h11, 27'h13);
    st_asid = 16'd4;
    look(27'h12, 27'h13);
    st_freq = 1'b1; st_mode = 2'd1; st_fvpn = 27'h12;
    step();
    look(27'h12, 27'h13);
    look(27'h11, 27'h13);
    refill_if(27'h14, 44'h1414, 1'b0);
    st_freq = 1'b1; st_mode = 2'd2; st_fasid = 16'd4;
    step();
    for (int i = 0; i < 5; i++) look(27'h14, 27'h13);
    st_rst = 1'b0;
    look(27'h14, 27'h13);
    st_rst = 1'b1;
    look(27'h14, 27'h13);
    look(27'h14, 27'h13);
    for (int i = 0; i < 3000; i++) begin
      st_rst    = ($urandom_range(0, 499) != 0);
      st_asid   = ($urandom_range(0, 1) != 0) ? 16'd3 : 16'd4;
      st_if_vpn = 27'(($urandom_range(0, 3) << 4) | $urandom_range(0, 3));
      st_ma_vpn = 27'(($urandom_range(0, 3) << 4) | $urandom_range(0, 3));
      st_fvpn   = 27'(($urandom_range(0, 3) << 4) | $urandom_range(0, 3));
      st_if_upd = ($urandom_range(0, 9) < 3);
      st_ma_upd = ($urandom_range(0, 9) < 3);
      st_if_wd  = 44'({$urandom(), $urandom()});
      st_ma_wd  = 44'({$urandom(), $urandom()});
      st_if_g   = ($urandom_range(0, 4) == 0);
      st_ma_g   = ($urandom_range(0, 4) == 0);
      st_freq   = ($urandom_range(0, 29) == 0);
      st_mode   = 2'($urandom_range(0, 3));
      st_fasid  = ($urandom_range(0, 1) != 0) ? 16'd3 : 16'd4;
      step();
    end
    st_rst = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    chk("scoreboard_drain", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
